// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned CNT_W     = $clog2(WIDTH_DEF);

  // Bit-counter width for a given operand width; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
// The ovf signal exists only when SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, bin, input busy, done, diff, bout);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bi, bo = borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, with start/busy/done handshake.
// Define SUB_OVF_EN to add the signed-overflow flag (ovf) and operand capture.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic clk,
  input  logic rst,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] res_new;
  logic             fs_d, fs_bo;
`ifdef SUB_OVF_EN
  logic [WIDTH-1:0] a_cap_q, a_cap_d;
  logic [WIDTH-1:0] b_cap_q, b_cap_d;
  logic             ovf_q, ovf_d;
`endif

  full_subtractor u_fs (
    .x  (a_sh_q[0]),
    .y  (b_sh_q[0]),
    .bi (br_q),
    .d  (fs_d),
    .bo (fs_bo)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
`ifdef SUB_OVF_EN
    a_cap_d = a_cap_q;
    b_cap_d = b_cap_q;
    ovf_d   = ovf_q;
`endif
    res_new = {fs_d, res_q[WIDTH-1:1]};

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          br_d    = bus.bin;
          cnt_d   = '0;
          res_d   = '0;
`ifdef SUB_OVF_EN
          a_cap_d = bus.a;
          b_cap_d = bus.b;
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        res_d  = res_new;
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = fs_bo;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          diff_d  = res_new;
          bout_d  = fs_bo;
`ifdef SUB_OVF_EN
          // Operand signs differ and the result sign departs from the minuend.
          ovf_d   = (a_cap_q[WIDTH-1] != b_cap_q[WIDTH-1]) &&
                    (res_new[WIDTH-1] != a_cap_q[WIDTH-1]);
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SUB_OVF_EN
      a_cap_q <= '0;
      b_cap_q <= '0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SUB_OVF_EN
      a_cap_q <= a_cap_d;
      b_cap_q <= b_cap_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
`ifdef SUB_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4); also covers SUB_OVF_EN builds.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  logic clk;
  logic rst;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  exp_t         sb_q[$];
  int unsigned  m_cnt  = 0;
  logic [W-1:0] h_diff = '0;
  logic         h_bout = 1'b0;
  logic         h_ovf  = 1'b0;
  int unsigned  n_done = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic exp_t ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    exp_t e;
    int   full;
    full   = int'(a) - int'(b) - int'(bin);
    e.diff = W'(full & 32'hF);
    e.bout = (int'(a) < int'(b) + int'(bin));
    e.ovf  = (a[W-1] != b[W-1]) && (e.diff[W-1] != a[W-1]);
    return e;
  endfunction

  // One clock: update the model at the rising edge, check outputs at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_cnt = 0;
      sb_q.delete();
      h_diff = '0;
      h_bout = 1'b0;
      h_ovf  = 1'b0;
    end else if (m_cnt == 0) begin
      if (bus.start === 1'b1) begin
        sb_q.push_back(ref_sub(bus.a, bus.b, bus.bin));
        m_cnt = W + 1;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 1) begin
        if (sb_q.size() == 0) check_eq("sb_underflow", 32'd0, 32'd1);
        else begin
          exp_t e;
          e = sb_q.pop_front();
          h_diff = e.diff;
          h_bout = e.bout;
          h_ovf  = e.ovf;
        end
      end
    end
    @(negedge clk);
    check_eq("busy", 32'(bus.busy), 32'(m_cnt != 0));
    check_eq("done", 32'(bus.done), 32'(m_cnt == 1));
    check_eq("diff", 32'(bus.diff), 32'(h_diff));
    check_eq("bout", 32'(bus.bout), 32'(h_bout));
`ifdef SUB_OVF_EN
    check_eq("ovf", 32'(bus.ovf), 32'(h_ovf));
`endif
    if (bus.done === 1'b1) n_done++;
  endtask

  task automatic wait_idle(input string tag);
    int unsigned guard;
    guard = 0;
    while (m_cnt != 0 && guard < 20) begin
      tick();
      guard++;
    end
    if (m_cnt != 0) check_eq({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_idle("op");
  endtask

  initial begin
    int unsigned d0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    tick();
    tick();
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_diff", 32'(bus.diff), 32'd0);
    rst = 1'b0;
    tick();

    // Basic subtract, including busy/done cycle placement.
    d0 = n_done;
    run_op(4'd9, 4'd5, 1'b0);
    check_eq("basic_diff", 32'(bus.diff), 32'd4);
    check_eq("basic_bout", 32'(bus.bout), 32'd0);
    check_eq("basic_ndone", n_done - d0, 32'd1);

    run_op(4'd3, 4'd5, 1'b0);
    check_eq("borrow_diff", 32'(bus.diff), 32'hE);
    check_eq("borrow_bout", 32'(bus.bout), 32'd1);
    run_op(4'd0, 4'd0, 1'b1);
    check_eq("bin_diff", 32'(bus.diff), 32'hF);
    check_eq("bin_bout", 32'(bus.bout), 32'd1);
    run_op(4'd6, 4'd6, 1'b0);
    check_eq("eq_diff", 32'(bus.diff), 32'd0);
    check_eq("eq_bout", 32'(bus.bout), 32'd0);

    run_op(4'd8, 4'd1, 1'b0);
    check_eq("ovf_diff", 32'(bus.diff), 32'd7);
    check_eq("ovf_bout", 32'(bus.bout), 32'd0);
`ifdef SUB_OVF_EN
    check_eq("ovf_set", 32'(bus.ovf), 32'd1);
`endif
    run_op(4'd7, 4'd1, 1'b0);
    check_eq("novf_diff", 32'(bus.diff), 32'd6);
`ifdef SUB_OVF_EN
    check_eq("ovf_clr", 32'(bus.ovf), 32'd0);
`endif

    // Start held high with operands changing every cycle: one op per W+2 cycles.
    d0 = n_done;
    bus.start = 1'b1;
    for (int i = 0; i < 36; i++) begin
      bus.a   = W'($urandom_range(0, 15));
      bus.b   = W'($urandom_range(0, 15));
      bus.bin = 1'($urandom_range(0, 1));
      tick();
    end
    bus.start = 1'b0;
    wait_idle("lockout");
    check_eq("lockout_ndone", n_done - d0, 32'd6);

    // Reset in the middle of an operation aborts it.
    d0 = n_done;
    bus.a = 4'd15; bus.b = 4'd1; bus.bin = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_diff", 32'(bus.diff), 32'd0);
    for (int i = 0; i < 8; i++) tick();
    check_eq("abort_ndone", n_done - d0, 32'd0);
    run_op(4'd15, 4'd1, 1'b0);
    check_eq("after_abort_diff", 32'(bus.diff), 32'd14);

    // Reset beats a simultaneous start.
    rst = 1'b1;
    bus.start = 1'b1;
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    tick();
    check_eq("rst_vs_start_busy", 32'(bus.busy), 32'd0);

    // Exhaustive sweep against the reference model.
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          run_op(W'(ia), W'(ib), 1'(ic));

    check_eq("sb_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
